// File: rtl/predicate_speculation_controller.sv
// rtl/predicate_speculation_controller.sv - 2-bit predicate predictor with in-order speculation FIFO and flush control
module predicate_speculation_controller #(
    parameter int NUM_PREDICATES = 8,
    parameter int MAX_IN_FLIGHT  = 4,
    localparam int IW = $clog2(NUM_PREDICATES),
    localparam int CW = $clog2(MAX_IN_FLIGHT + 1)
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_enable,
    input  logic          i_predict_request,
    input  logic [IW-1:0] i_predict_index,
    output logic          o_predict_grant,
    output logic          o_predicted_value,
    input  logic          i_resolve_valid,
    input  logic [IW-1:0] i_resolve_index,
    input  logic          i_resolve_value,
    output logic          o_mispredict,
    output logic [CW-1:0] o_flush_count,
    output logic [CW-1:0] o_in_flight,
    output logic          o_speculating
);

    localparam int PW = (MAX_IN_FLIGHT > 1) ? $clog2(MAX_IN_FLIGHT) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SPEC    = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    logic [1:0]    r_ctr      [NUM_PREDICATES];
    logic [IW-1:0] r_fifo_idx [MAX_IN_FLIGHT];
    logic          r_fifo_val [MAX_IN_FLIGHT];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_in_flight;
    logic [CW-1:0] r_flush_count;
    logic [1:0]    r_state;

    logic          w_head_match;
    logic          w_mispredict_now;
    logic          w_pop;
    logic          w_grant;
    logic          w_predicted;
    logic [CW-1:0] w_next_count;

    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_IN_FLIGHT - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_predicted      = r_ctr[i_predict_index][1];
    assign w_head_match     = i_resolve_valid && i_enable && (r_in_flight != '0)
                              && (i_resolve_index == r_fifo_idx[r_head]);
    assign w_mispredict_now = w_head_match && (i_resolve_value != r_fifo_val[r_head]);
    assign w_pop            = w_head_match && !w_mispredict_now;
    // Full is judged on the registered count, so a pop never frees a slot for a same-cycle push
    assign w_grant          = i_enable && i_predict_request && (r_state != ST_RECOVER)
                              && (r_in_flight < CW'(MAX_IN_FLIGHT)) && !w_mispredict_now;
    assign w_next_count     = r_in_flight + CW'(w_grant) - CW'(w_pop);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_PREDICATES; i++) begin
                r_ctr[i] <= 2'b01;
            end
            r_head        <= '0;
            r_tail        <= '0;
            r_in_flight   <= '0;
            r_flush_count <= '0;
            r_state       <= ST_IDLE;
        end else if (i_enable) begin
            // Training is independent of whether the resolve hits the FIFO head
            if (i_resolve_valid) begin
                if (i_resolve_value && r_ctr[i_resolve_index] != 2'b11) begin
                    r_ctr[i_resolve_index] <= r_ctr[i_resolve_index] + 2'b01;
                end else if (!i_resolve_value && r_ctr[i_resolve_index] != 2'b00) begin
                    r_ctr[i_resolve_index] <= r_ctr[i_resolve_index] - 2'b01;
                end
            end
            if (w_mispredict_now) begin
                r_head        <= '0;
                r_tail        <= '0;
                r_in_flight   <= '0;
                r_flush_count <= r_in_flight - CW'(1);
                r_state       <= ST_RECOVER;
            end else begin
                if (w_pop) begin
                    r_head <= f_ptr_inc(r_head);
                end
                if (w_grant) begin
                    r_tail <= f_ptr_inc(r_tail);
                end
                r_in_flight   <= w_next_count;
                r_flush_count <= '0;
                r_state       <= (w_next_count != '0) ? ST_SPEC : ST_IDLE;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset && w_grant) begin
            r_fifo_idx[r_tail] <= i_predict_index;
            r_fifo_val[r_tail] <= w_predicted;
        end
    end

    assign o_predict_grant   = w_grant;
    assign o_predicted_value = w_predicted;
    assign o_mispredict      = (r_state == ST_RECOVER);
    assign o_flush_count     = r_flush_count;
    assign o_in_flight       = r_in_flight;
    assign o_speculating     = (r_in_flight != '0);

endmodule

// File: tb/tb_predicate_speculation_controller.sv
// tb/tb_predicate_speculation_controller.sv - randomized bench against a queue-based reference model
module tb_predicate_speculation_controller;

    localparam int NP  = 8;
    localparam int MIF = 4;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       predict_request;
    logic [2:0] predict_index;
    logic       predict_grant;
    logic       predicted_value;
    logic       resolve_valid;
    logic [2:0] resolve_index;
    logic       resolve_value;
    logic       mispredict;
    logic [2:0] flush_count;
    logic [2:0] in_flight;
    logic       speculating;

    predicate_speculation_controller #(.NUM_PREDICATES(NP), .MAX_IN_FLIGHT(MIF)) dut (
        .i_clock           (clock),
        .i_reset           (reset),
        .i_enable          (enable),
        .i_predict_request (predict_request),
        .i_predict_index   (predict_index),
        .o_predict_grant   (predict_grant),
        .o_predicted_value (predicted_value),
        .i_resolve_valid   (resolve_valid),
        .i_resolve_index   (resolve_index),
        .i_resolve_value   (resolve_value),
        .o_mispredict      (mispredict),
        .o_flush_count     (flush_count),
        .o_in_flight       (in_flight),
        .o_speculating     (speculating)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int idx;
        int val;
    } ent_t;

    ent_t mq[$];
    int   mctr[NP];
    bit   mrec;
    int   mfc;
    int   n_tests;
    int   n_fail;
    bit   got_grant;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit preq, input int pi,
                        input bit rv, input int ri, input bit rval);
        bit exp_pred;
        bit mis_now;
        bit exp_grant;
        @(negedge clock);
        reset           = rst;
        enable          = en;
        predict_request = preq;
        predict_index   = 3'(pi);
        resolve_valid   = rv;
        resolve_index   = 3'(ri);
        resolve_value   = rval;
        #1;
        exp_pred  = (mctr[pi] >= 2);
        mis_now   = en && rv && (mq.size() > 0) && (mq[0].idx == ri) && (mq[0].val != int'(rval));
        exp_grant = en && preq && !mrec && (mq.size() < MIF) && !mis_now;
        check("grant", 32'(predict_grant), 32'(exp_grant));
        check("predicted_value", 32'(predicted_value), 32'(exp_pred));
        got_grant = predict_grant;
        @(posedge clock);
        if (rst) begin
            foreach (mctr[i]) mctr[i] = 1;
            mq.delete();
            mrec = 0;
            mfc  = 0;
        end else if (en) begin
            if (mrec) begin
                mrec = 0;
                mfc  = 0;
            end
            if (mis_now) begin
                mfc = mq.size() - 1;
                mq.delete();
                mrec = 1;
            end else if (rv && mq.size() > 0 && mq[0].idx == ri) begin
                void'(mq.pop_front());
            end
            if (exp_grant) mq.push_back('{idx: pi, val: int'(exp_pred)});
            if (rv) begin
                if (rval) mctr[ri] = (mctr[ri] < 3) ? mctr[ri] + 1 : 3;
                else      mctr[ri] = (mctr[ri] > 0) ? mctr[ri] - 1 : 0;
            end
        end
        #1;
        check("mispredict", 32'(mispredict), 32'(mrec));
        check("flush_count", 32'(flush_count), mrec ? 32'(mfc) : 32'd0);
        check("in_flight", 32'(in_flight), 32'(mq.size()));
        check("speculating", 32'(speculating), 32'(mq.size() != 0));
    endtask

    task automatic idle_step(input int pi);
        step(0, 1, 0, pi, 0, 0, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        foreach (mctr[i]) mctr[i] = 1;
        mrec = 0;
        mfc  = 0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 3, 1, 3, 1);
        check("reset_in_flight", 32'(in_flight), 32'd0);
        check("reset_mispredict", 32'(mispredict), 32'd0);

        // Predict idx 3, then resolve it correctly
        step(0, 1, 1, 3, 0, 0, 0);
        check("r33_grant", 32'(got_grant), 32'd1);
        check("r33_in_flight", 32'(in_flight), 32'd1);
        step(0, 1, 0, 0, 1, 3, 0);
        check("r33_pop", 32'(in_flight), 32'd0);
        check("r33_no_mispredict", 32'(mispredict), 32'd0);
        idle_step(3);
        check("r33_ctr3", 32'(predicted_value), 32'd0);

        // Train idx 2 upward three times
        step(0, 1, 0, 2, 1, 2, 1);
        check("r34_after_first", 32'(predicted_value), 32'd1);
        step(0, 1, 0, 2, 1, 2, 1);
        step(0, 1, 0, 2, 1, 2, 1);
        idle_step(2);

        // Fill the FIFO, then pop with a same-cycle request
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, i, 0, 0, 0);
        check("r35_full", 32'(in_flight), 32'd4);
        step(0, 1, 1, 5, 0, 0, 0);
        check("r35_fifth_grant", 32'(got_grant), 32'd0);
        step(0, 1, 1, 5, 1, 0, 0);
        check("r35_pop_no_bypass", 32'(got_grant), 32'd0);
        step(0, 1, 1, 5, 0, 0, 0);
        check("r35_next_grant", 32'(got_grant), 32'd1);

        // Mispredict with three outstanding
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 4; i < 7; i++) step(0, 1, 1, i, 0, 0, 0);
        step(0, 1, 0, 0, 1, 4, 1);
        check("r36_mispredict", 32'(mispredict), 32'd1);
        check("r36_flush", 32'(flush_count), 32'd2);
        check("r36_in_flight", 32'(in_flight), 32'd0);
        step(0, 1, 1, 1, 0, 0, 0);
        check("r36_recover_grant", 32'(got_grant), 32'd0);
        check("r36_exit", 32'(mispredict), 32'd0);

        // RECOVER held by enable low, then reset mid-speculation
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 7, 0, 0, 0);
        step(0, 1, 0, 0, 1, 7, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 7, 1, 7, 1);
            check("r37_held", 32'(mispredict), 32'd1);
        end
        step(0, 1, 0, 7, 0, 0, 0);
        check("r37_exit", 32'(mispredict), 32'd0);
        step(0, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 2, 0, 0, 0);
        step(1, 1, 1, 3, 1, 1, 1);
        check("r37_reset_in_flight", 32'(in_flight), 32'd0);
        check("r37_reset_spec", 32'(speculating), 32'd0);
        idle_step(1);

        for (int c = 0; c < 3000; c++) begin
            bit rst_r;
            int ri_r;
            rst_r = ($urandom_range(0, 63) == 0);
            ri_r  = $urandom_range(0, NP - 1);
            if (mq.size() > 0 && $urandom_range(0, 1) == 1) ri_r = mq[0].idx;
            step(rst_r, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, NP - 1), 1'($urandom_range(0, 1)), ri_r,
                 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/predicate_speculation_controller.md
PREDICATE_SPECULATION_CONTROLLER -- requirements
Module: predicate_speculation_controller

Interface
REQ-001 Parameter NUM_PREDICATES, default 8: number of predicates tracked; index width IW = $clog2(NUM_PREDICATES).
REQ-002 Parameter MAX_IN_FLIGHT, default 4: maximum outstanding unresolved predictions; count width CW = $clog2(MAX_IN_FLIGHT+1).
REQ-003 clock  input  1  positive-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  active-high; when low, no state update and predict_grant = 0.
REQ-006 predict_request  input  1  trigger stage requests a speculative predicate value.
REQ-007 predict_index  input  IW  predicate to predict.
REQ-008 predict_grant  output  1  request accepted this cycle; entry pushed at clock edge.
REQ-009 predicted_value  output  1  prediction for predict_index, combinational.
REQ-010 resolve_valid  input  1  datapath writes a predicate this cycle.
REQ-011 resolve_index  input  IW  predicate being written.
REQ-012 resolve_value  input  1  value written.
REQ-013 mispredict  output  1  registered one-cycle flush pulse.
REQ-014 flush_count  output  CW  number of younger speculative entries discarded; valid while mispredict = 1, else 0.
REQ-015 in_flight  output  CW  current outstanding entry count, registered.
REQ-016 speculating  output  1  in_flight != 0.

Function
REQ-017 Per predicate, a 2-bit saturating counter: 00 strong-0, 01 weak-0, 10 weak-1, 11 strong-1; predicted_value = MSB of counter[predict_index], pre-update value.
REQ-018 On resolve_valid && enable: counter[resolve_index] increments (saturating at 11) if resolve_value = 1, else decrements (saturating at 00); applies whether or not the predicate is outstanding.
REQ-019 Outstanding entries held in FIFO order, each {index, predicted value}, depth MAX_IN_FLIGHT.
REQ-020 FSM states: IDLE (in_flight = 0), SPECULATING (in_flight > 0), RECOVER (one cycle after mispredict).
REQ-021 Head match: resolve_valid && enable && in_flight > 0 && resolve_index == head index; non-matching or empty-queue resolves only train (REQ-018).
REQ-022 Head match with equal value: head popped; next state SPECULATING if remaining count > 0, else IDLE.
REQ-023 Head match with differing value (mispredict_now): entire FIFO cleared, next state RECOVER, flush_count registered as in_flight - 1.
REQ-024 mispredict = (state == RECOVER); RECOVER exits to IDLE after exactly one enabled cycle; held while enable = 0.
REQ-025 predict_grant = enable && predict_request && state != RECOVER && in_flight < MAX_IN_FLIGHT && !mispredict_now; no same-cycle full bypass from a pop.
REQ-026 Simultaneous grant and correct head pop: push and pop both occur; in_flight unchanged.
REQ-027 Simultaneous request and mispredict_now: grant = 0, nothing pushed.
REQ-028 Same predicate may have multiple outstanding entries; each resolves in FIFO order.
REQ-029 FIFO pointers wrap modulo MAX_IN_FLIGHT; in_flight never exceeds MAX_IN_FLIGHT or underflows.
REQ-030 Prediction for an index equal to a same-cycle resolve_index uses the pre-update counter.

Reset
REQ-031 On reset: all counters 01, FIFO empty, state IDLE, in_flight 0, speculating 0, mispredict 0, flush_count 0, hence predicted_value 0.
REQ-032 Reset overrides enable and any in-flight request or resolve, including during RECOVER; no mispredict pulse follows reset.

Verification
REQ-033 After reset, predict index 3 -> predicted_value 0, grant 1, in_flight 1; resolve idx 3 val 0 -> pop, in_flight 0, mispredict stays 0, counter[3] = 00.
REQ-034 Three resolves idx 2 val 1 from reset -> counter[2] 01->10->11->11; predicted_value for idx 2 = 1 after first.
REQ-035 Push 4 entries (idx 0,1,2,3, all predicted 0) -> 5th request grant 0; resolve idx 0 val 0 with request same cycle -> grant 0, next cycle grant 1.
REQ-036 With 3 outstanding, resolve head val 1 (predicted 0) -> next cycle mispredict 1, flush_count 2, in_flight 0; request during RECOVER -> grant 0; following cycle mispredict 0, IDLE.
REQ-037 enable = 0 during RECOVER for 3 cycles -> mispredict held 1, counters unchanged, grant 0; reset asserted mid-speculation -> all outputs at REQ-031 values next cycle.
